// File: rtl/puf_uart_bridge.sv
// puf_uart_bridge
//   Frames PUF challenges arriving over a UART byte stream and returns the
//   PUF response over the same UART. A frame is HEADER followed by CHAL_BYTES
//   challenge bytes (big-endian). The assembled challenge is offered on a
//   valid/ready handshake, and the response is accepted on a second handshake.
//   The response is then sent back one byte at a time, most significant byte
//   first.
//
// Ports
//   clk, areset            system clock, synchronous active-high reset
//   rx_data, rx_valid      byte stream from the UART receiver
//   rx_enable              receiver enable (high while idle/collecting)
//   tx_data, tx_enable     byte + one-cycle send request to the UART transmitter
//   tx_busy                transmitter busy
//   challenge, chal_valid, chal_ready   challenge handshake toward the PUF
//   response, resp_valid, resp_ready    response handshake from the PUF
//   frame_err              one-cycle pulse when a partial frame is abandoned
//
// Configuration
//   PUF_UART_TIMEOUT_EN    when defined, a frame stalled for TIMEOUT_CYCLES
//                          between challenge bytes is dropped and frame_err
//                          pulses; when undefined, frame_err is constant 0.
module puf_uart_bridge #(
  parameter int                   DATA_BITS      = 8,
  parameter int                   CHAL_BYTES     = 8,
  parameter int                   RESP_BYTES     = 4,
  parameter logic [DATA_BITS-1:0] HEADER         = DATA_BITS'(8'h55),
  parameter int                   TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                             clk,
  input  logic                             areset,
  input  logic [DATA_BITS-1:0]             rx_data,
  input  logic                             rx_valid,
  output logic                             rx_enable,
  output logic [DATA_BITS-1:0]             tx_data,
  output logic                             tx_enable,
  input  logic                             tx_busy,
  output logic [CHAL_BYTES*DATA_BITS-1:0]  challenge,
  output logic                             chal_valid,
  input  logic                             chal_ready,
  input  logic [RESP_BYTES*DATA_BITS-1:0]  response,
  input  logic                             resp_valid,
  output logic                             resp_ready,
  output logic                             frame_err
);

  localparam int CHAL_W = CHAL_BYTES * DATA_BITS;
  localparam int RESP_W = RESP_BYTES * DATA_BITS;
  localparam int CNT_W  = 5;

  localparam logic [CNT_W-1:0] LAST_CHAL = CNT_W'(CHAL_BYTES - 1);
  localparam logic [CNT_W-1:0] ALL_RESP  = CNT_W'(RESP_BYTES);
  localparam logic [1:0]       GUARD     = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    RX_CHAL,
    CHAL_OUT,
    RESP_WAIT,
    TX_LOAD,
    TX_WAIT
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [CNT_W-1:0]    byte_cnt;   // challenge bytes received, then response bytes sent
  logic [1:0]          guard_cnt;
  logic [CHAL_W-1:0]   chal_reg;
  logic [RESP_W-1:0]   resp_reg;   // shifts left as bytes go out
  logic [DATA_BITS-1:0] tx_data_r;

`ifdef PUF_UART_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] idle_cnt;
`endif

  assign challenge = chal_reg;
  // The byte is presented combinationally in the send cycle so tx_enable can
  // fire the cycle TX_LOAD is entered; the register then holds it until the
  // next send.
  assign tx_data = tx_enable ? resp_reg[RESP_W-1 -: DATA_BITS] : tx_data_r;

  always_comb begin
    state_nxt  = state;
    rx_enable  = 1'b0;
    chal_valid = 1'b0;
    resp_ready = 1'b0;
    tx_enable  = 1'b0;
    frame_err  = 1'b0;
    case (state)
      IDLE: begin
        rx_enable = 1'b1;
        if (rx_valid && rx_data == HEADER) state_nxt = RX_CHAL;
      end
      RX_CHAL: begin
        rx_enable = 1'b1;
        if (rx_valid) begin
          if (byte_cnt == LAST_CHAL) state_nxt = CHAL_OUT;
        end
`ifdef PUF_UART_TIMEOUT_EN
        else if (idle_cnt == TO_LAST) begin
          frame_err = 1'b1;
          state_nxt = IDLE;
        end
`endif
      end
      CHAL_OUT: begin
        chal_valid = 1'b1;
        if (chal_ready) state_nxt = RESP_WAIT;
      end
      RESP_WAIT: begin
        resp_ready = 1'b1;
        if (resp_valid) state_nxt = TX_LOAD;
      end
      TX_LOAD: begin
        if (!tx_busy) begin
          tx_enable = 1'b1;
          state_nxt = TX_WAIT;
        end
      end
      TX_WAIT: begin
        if (guard_cnt == GUARD && !tx_busy)
          state_nxt = (byte_cnt == ALL_RESP) ? IDLE : TX_LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state     <= IDLE;
      byte_cnt  <= '0;
      guard_cnt <= '0;
      chal_reg  <= '0;
      resp_reg  <= '0;
      tx_data_r <= '0;
`ifdef PUF_UART_TIMEOUT_EN
      idle_cnt  <= '0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          byte_cnt <= '0;
`ifdef PUF_UART_TIMEOUT_EN
          idle_cnt <= '0;
`endif
        end
        RX_CHAL: begin
          if (rx_valid) begin
            chal_reg <= (chal_reg << DATA_BITS) | CHAL_W'(rx_data);
            byte_cnt <= byte_cnt + 1'b1;
`ifdef PUF_UART_TIMEOUT_EN
            idle_cnt <= '0;
`endif
          end
`ifdef PUF_UART_TIMEOUT_EN
          else if (frame_err) begin
            chal_reg <= '0;
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
`endif
        end
        RESP_WAIT: begin
          if (resp_valid) begin
            resp_reg <= response;
            byte_cnt <= '0;
          end
        end
        TX_LOAD: begin
          if (tx_enable) begin
            tx_data_r <= tx_data;
            resp_reg  <= resp_reg << DATA_BITS;
            byte_cnt  <= byte_cnt + 1'b1;
            guard_cnt <= '0;
          end
        end
        TX_WAIT: begin
          if (guard_cnt != GUARD) guard_cnt <= guard_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_uart_bridge.sv
// Self-checking bench for puf_uart_bridge (default 8/8/4 geometry,
// TIMEOUT_CYCLES overridden to 100; the timeout scenario runs only when
// PUF_UART_TIMEOUT_EN is defined).
module tb_puf_uart_bridge;

  localparam int RB = 4;

  logic        clk = 1'b0;
  logic        areset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_enable;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_busy;
  logic [63:0] challenge;
  logic        chal_valid;
  logic        chal_ready;
  logic [31:0] response;
  logic        resp_valid;
  logic        resp_ready;
  logic        frame_err;

  always #5 clk = ~clk;

  puf_uart_bridge #(
    .DATA_BITS      (8),
    .CHAL_BYTES     (8),
    .RESP_BYTES     (4),
    .HEADER         (8'h55),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_enable  (rx_enable),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .tx_busy    (tx_busy),
    .challenge  (challenge),
    .chal_valid (chal_valid),
    .chal_ready (chal_ready),
    .response   (response),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .frame_err  (frame_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic fail_evt(input string nm, input string act, input string req);
    total++;
    bad++;
    $display("FAIL %s: actual=%s required=%s", nm, act, req);
  endtask

  // UART transmitter stand-in: busy for 10 cycles after each send request.
  int busy_cnt = 0;
  always @(posedge clk) begin
    if (areset)          busy_cnt <= 0;
    else if (tx_enable)  busy_cnt <= 10;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  // Behavioural model: expected challenges in frame order, expected transmit
  // bytes derived from each accepted response (MSB byte first).
  logic [63:0] chal_q[$];
  logic [7:0]  tx_q[$];
  logic [7:0]  sent_q[$];
  int          pulse_cyc[$];
  logic [63:0] held_chal = '0;
  logic        prev_cv   = 1'b0;
  logic [7:0]  last_tx   = '0;
  int          cyc       = 0;
  int          last_rx_cyc = 0;
  int          exp_ferr_cyc = -1;
  int          ferr_seen = 0;
  bit          cmp_on    = 1'b0;

  always @(negedge clk) begin
    if (areset) begin
      tx_q.delete();
      prev_cv = 1'b0;
      last_tx = '0;
    end else if (cmp_on) begin
      if (chal_valid && !prev_cv) begin
        if (chal_q.size() == 0) fail_evt("chal_unexpected", "chal_valid", "no_frame_pending");
        else check("challenge", challenge, chal_q.pop_front());
        held_chal = challenge;
      end else if (chal_valid) begin
        check("chal_stable", challenge, held_chal);
      end
      if (resp_valid && resp_ready)
        for (int i = RB - 1; i >= 0; i--) tx_q.push_back(response[i*8 +: 8]);
      if (tx_enable) begin
        if (tx_q.size() == 0) fail_evt("tx_unexpected", "tx_enable", "no_byte_pending");
        else check("tx_byte", tx_data, tx_q.pop_front());
        check("tx_while_busy", tx_busy, 0);
        last_tx = tx_data;
        sent_q.push_back(tx_data);
        pulse_cyc.push_back(cyc);
      end else begin
        check("tx_hold", tx_data, last_tx);
      end
      check("rx_enable_excl", rx_enable && (chal_valid || resp_ready || tx_enable), 0);
      check("frame_err", frame_err, (cyc == exp_ferr_cyc));
      if (frame_err) ferr_seen++;
      if (rx_valid) last_rx_cyc = cyc;
      prev_cv = chal_valid;
    end
    cyc++;
  end

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [63:0] ch, output logic [63:0] got);
    logic [7:0] b;
    chal_q.push_back(ch);
    send_byte(8'h55);
    for (int i = 7; i >= 0; i--) begin
      b = ch[i*8 +: 8];
      send_byte(b);
    end
    @(negedge clk);
    check("chal_latency", chal_valid, 1);
    got = challenge;
    tick();
  endtask

  task automatic handshake_resp(input logic [31:0] r);
    int n = 0;
    while (!resp_ready && n < 200) begin
      tick();
      n++;
    end
    if (!resp_ready) begin
      fail_evt("resp_ready_wait", "timeout", "resp_ready");
    end else begin
      response   = r;
      resp_valid = 1'b1;
      tick();
      resp_valid = 1'b0;
      check("resp_ready_drop", resp_ready, 0);
      @(negedge clk);
      check("tx_latency", tx_enable, 1);
      tick();
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!rx_enable && n < 500) begin
      tick();
      n++;
    end
    check("back_to_idle", rx_enable, 1);
    check("tx_all_sent", tx_q.size(), 0);
  endtask

  logic [63:0] got;
  int          n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset     = 1'b1;
    rx_data    = '0;
    rx_valid   = 1'b0;
    chal_ready = 1'b1;
    response   = '0;
    resp_valid = 1'b0;
    repeat (3) tick();
    areset = 1'b0;
    cmp_on = 1'b1;

    // Reset values
    check("rst_rx_enable",  rx_enable, 1);
    check("rst_tx_enable",  tx_enable, 0);
    check("rst_tx_data",    tx_data, 0);
    check("rst_challenge",  challenge, 0);
    check("rst_chal_valid", chal_valid, 0);
    check("rst_resp_ready", resp_ready, 0);
    check("rst_frame_err",  frame_err, 0);

    // Basic frame and DEADBEEF response through a 10-cycle-busy transmitter
    send_frame(64'h0102030405060708, got);
    check("chal_literal", got, 64'h0102030405060708);
    check("chal_valid_drop", chal_valid, 0);
    check("resp_ready_up", resp_ready, 1);
    sent_q.delete();
    pulse_cyc.delete();
    handshake_resp(32'hDEADBEEF);
    wait_idle();
    check("tx_count", sent_q.size(), 4);
    if (sent_q.size() == 4) begin
      check("tx_b0", sent_q[0], 8'hDE);
      check("tx_b1", sent_q[1], 8'hAD);
      check("tx_b2", sent_q[2], 8'hBE);
      check("tx_b3", sent_q[3], 8'hEF);
      for (int i = 1; i < 4; i++) check("tx_gap", pulse_cyc[i] - pulse_cyc[i-1], 12);
    end

    // Junk bytes in idle are dropped; header inside a frame is data
    send_byte(8'h00);
    send_byte(8'hAA);
    check("junk_idle", rx_enable, 1);
    check("junk_no_chal", chal_valid, 0);
    send_frame(64'h55123456789ABCDE, got);
    check("chal_hdr_data", got, 64'h55123456789ABCDE);
    handshake_resp(32'h01A2C3F4);
    wait_idle();

    // Consumer stalls for 50 cycles; received bytes are ignored meanwhile
    chal_ready = 1'b0;
    send_frame(64'hF0E1D2C3B4A59687, got);
    for (int i = 0; i < 50; i++) begin
      if (i % 7 == 0) send_byte(8'h55);
      else tick();
      check("hold_rx_enable", rx_enable, 0);
      check("hold_chal_valid", chal_valid, 1);
    end
    check("hold_chal_value", challenge, 64'hF0E1D2C3B4A59687);
    chal_ready = 1'b1;
    tick();
    check("hold_release", chal_valid, 0);
    send_byte(8'h55);
    handshake_resp(32'h13579BDF);
    wait_idle();

    // Reset during TX_WAIT after the second byte
    send_frame(64'h0011223344556677, got);
    sent_q.delete();
    handshake_resp(32'hCAFEF00D);
    n = 0;
    while (sent_q.size() < 2 && n < 200) begin
      tick();
      n++;
    end
    check("mid_tx_pulses", sent_q.size(), 2);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    @(negedge clk);
    check("mr_rx_enable",  rx_enable, 1);
    check("mr_tx_enable",  tx_enable, 0);
    check("mr_tx_data",    tx_data, 0);
    check("mr_challenge",  challenge, 0);
    check("mr_chal_valid", chal_valid, 0);
    check("mr_resp_ready", resp_ready, 0);
    check("mr_frame_err",  frame_err, 0);
    tick();
    repeat (40) tick();
    check("mr_no_more_tx", sent_q.size(), 2);

`ifdef PUF_UART_TIMEOUT_EN
    // Stalled partial frame is dropped after 100 idle cycles
    send_byte(8'h55);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    exp_ferr_cyc = last_rx_cyc + 100;
    repeat (120) tick();
    check("to_ferr_count", ferr_seen, 1);
    check("to_idle", rx_enable, 1);
    check("to_no_chal", chal_valid, 0);
`endif

    // Recovery: a full frame after the disturbances
    send_frame(64'hA5A5_0F0F_7E81_C33C, got);
    check("recover_chal", got, 64'hA5A50F0F7E81C33C);
    handshake_resp(32'h89ABCDEF);
    wait_idle();
    check("ferr_total", ferr_seen,
`ifdef PUF_UART_TIMEOUT_EN
          1
`else
          0
`endif
    );

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/puf_uart_bridge.md
PUF_UART_BRIDGE -- requirements
Module: puf_uart_bridge

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, UART payload width in bits.
REQ-002 SHALL have parameter CHAL_BYTES, default 8, number of challenge bytes per frame (range 1..16).
REQ-003 SHALL have parameter RESP_BYTES, default 4, number of response bytes per frame (range 1..16).
REQ-004 SHALL have parameter HEADER, default 8'h55, frame start byte.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, inter-byte timeout in clk cycles.
REQ-006 clk  input  1  system clock; single clock domain, all logic on rising edge.
REQ-007 areset  input  1  reset, synchronous, active-high.
REQ-008 rx_data  input  DATA_BITS  byte from UART receiver.
REQ-009 rx_valid  input  1  single-cycle pulse, rx_data valid.
REQ-010 rx_enable  output  1  enables UART receiver.
REQ-011 tx_data  output  DATA_BITS  byte to UART transmitter.
REQ-012 tx_enable  output  1  single-cycle send request.
REQ-013 tx_busy  input  1  UART transmitter busy.
REQ-014 challenge  output  CHAL_BYTES*DATA_BITS  assembled challenge.
REQ-015 chal_valid / chal_ready  output / input  1 each  challenge handshake.
REQ-016 response  input  RESP_BYTES*DATA_BITS  PUF response.
REQ-017 resp_valid / resp_ready  input / output  1 each  response handshake.
REQ-018 frame_err  output  1  single-cycle pulse on aborted frame.

Function
REQ-019 FSM states SHALL be IDLE, RX_CHAL, CHAL_OUT, RESP_WAIT, TX_LOAD, TX_WAIT.
REQ-020 IDLE: rx_valid with rx_data==HEADER -> RX_CHAL, byte counter cleared; any other byte dropped, no error.
REQ-021 RX_CHAL: each rx_valid shifts rx_data into challenge register, first received byte ending in MSBs (big-endian); after CHAL_BYTES-th byte -> CHAL_OUT on next cycle.
REQ-022 A HEADER value received inside RX_CHAL SHALL be treated as data, not as a new frame start.
REQ-023 rx_enable SHALL be 1 in IDLE and RX_CHAL, 0 in all other states; rx_valid outside IDLE/RX_CHAL ignored.
REQ-024 CHAL_OUT: chal_valid=1, challenge stable; transfer on chal_valid&&chal_ready -> RESP_WAIT, chal_valid drops next cycle.
REQ-025 RESP_WAIT: resp_ready=1; on resp_valid&&resp_ready response registered internally -> TX_LOAD; resp_ready=0 in all other states.
REQ-026 TX_LOAD: when tx_busy==0, drive tx_data with next response byte (MSB byte first) and pulse tx_enable for exactly one cycle -> TX_WAIT.
REQ-027 TX_WAIT: ignore tx_busy for 2 guard cycles, then wait tx_busy==0; if bytes remain -> TX_LOAD, else -> IDLE.
REQ-028 tx_data SHALL hold its value from the tx_enable cycle until the next tx_enable.
REQ-029 Latency: last challenge byte rx_valid to chal_valid high = 1 cycle; resp handshake to first tx_enable = 1 cycle when tx_busy==0.
REQ-030 rx_valid coinciding with a state transition SHALL be evaluated in the pre-transition state.

Reset
REQ-031 areset sampled at rising clk SHALL force IDLE, clear counters and registers; outputs: rx_enable=1 (IDLE value), tx_enable=0, tx_data=0, challenge=0, chal_valid=0, resp_ready=0, frame_err=0.
REQ-032 areset mid-frame (any state) SHALL abandon the frame without frame_err; areset has priority over all inputs.

Configuration
REQ-033 Macro PUF_UART_TIMEOUT_EN defined: in RX_CHAL an idle counter reloads on each rx_valid; reaching TIMEOUT_CYCLES without a byte -> IDLE with one-cycle frame_err pulse, partial challenge discarded.
REQ-034 Macro undefined: no timeout counter synthesised, RX_CHAL waits indefinitely, frame_err tied 0.

Verification
REQ-035 Send 0x55,01..08, chal_ready=1 -> challenge=64'h0102030405060708, chal_valid 1 cycle after byte 08.
REQ-036 Bytes 0x00,0xAA then 0x55 + 8 bytes -> first two dropped, single correct challenge, frame_err never asserted.
REQ-037 response=32'hDEADBEEF, tx_busy model 10 cycles per byte -> four tx_enable pulses with tx_data DE,AD,BE,EF in order, then IDLE.
REQ-038 chal_ready held 0 for 50 cycles -> chal_valid and challenge stable throughout; rx bytes during hold ignored.
REQ-039 PUF_UART_TIMEOUT_EN, TIMEOUT_CYCLES=100: 0x55 + 3 bytes then silence -> frame_err pulse ~100 cycles after 3rd byte, IDLE, next full frame correct.
REQ-040 areset asserted in TX_WAIT after 2nd byte -> no further tx_enable, all outputs at reset values next cycle.
